hatch_seq_ctrl: RTL and testbench
=================================

Name: hatch_seq_ctrl

Overview:
Incubation sequencer for the egg-hatch dot-matrix display. It times the 12 hatching stages from the 1 kHz system clock and drives the stage number, display enable and temperature-fault flag consumed by the dot-matrix driver. Progress advances only while the thermal sensor reports in-range temperature. Start/stop keys pause, resume, abort and re-arm the sequence.

Parameters:
STAGE_MS, 1000, in-range clock ticks per stage (ms at 1 kHz); must be >= 2
LAST_STAGE, 11, final stage number; the sequence ends when num reaches it; range 1..15
ALARM_MS, 5000, consecutive out-of-range ticks before alarm (used only with the optional feature)

Ports:
clk  input  1  1 kHz system clock
rst  input  1  asynchronous active-high reset
start_key  input  1  one-cycle pulse, debounced upstream, synchronous to clk
stop_key  input  1  one-cycle pulse, debounced upstream, synchronous to clk
temp_ok  input  1  1 = incubator temperature in range; synchronous to clk
num  output  4  current stage 0..LAST_STAGE, to display driver
st  output  1  display enable, 1 while a sequence is active or finished
temp  output  1  temperature-fault overlay request to display driver
done  output  1  1 while in DONE
alarm  output  1  sustained-fault alarm; constant 0 unless HATCH_ALARM_EN

Behaviour:
- Clocking/reset: single clock clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, num=0, st=0, temp=0, done=0, alarm=0, ms_cnt=0.
- ms_cnt width is $clog2(STAGE_MS). It counts 0..STAGE_MS-1.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - Outputs: st=0, num=0.
  - start_key -> RUN, with ms_cnt=0 and num=0.
- RUN (st=1):
  - If temp_ok=1, ms_cnt increments.
  - At ms_cnt==STAGE_MS-1 with temp_ok=1: ms_cnt wraps to 0 and num increments. The new num is visible on the next edge; latency is 1 cycle after the terminal tick.
  - If temp_ok=0, ms_cnt and num hold. There is no clear.
  - When num increments to LAST_STAGE -> DONE, in the same edge.
  - stop_key -> HOLD.
- HOLD (st=1):
  - ms_cnt and num are frozen.
  - start_key -> RUN. The sequence resumes from the frozen count; no time is lost.
  - stop_key -> IDLE (abort). num and ms_cnt clear.
- DONE:
  - Outputs: st=1, done=1, num=LAST_STAGE.
  - temp_ok is ignored; the temp output is forced to 0.
  - start_key or stop_key -> IDLE.
- Simultaneous start_key and stop_key: stop wins in every state. In IDLE, nothing happens.
- Terminal tick coinciding with stop_key in RUN: stop has priority. The state goes to HOLD, and ms_cnt and num keep their pre-edge values.
- temp output: registered ~temp_ok while in RUN or HOLD; 0 otherwise. One-cycle latency.
- done: registered decode of the DONE state.
- Mid-operation reset: immediate return to the reset values. No partial stage is retained.
- num never exceeds LAST_STAGE. There is no wrap-around past the final stage.

Optional Feature:
Macro: HATCH_ALARM_EN.
- Defined:
  - A bad-temperature counter (width $clog2(ALARM_MS+1)) increments each tick in RUN or HOLD while temp_ok=0.
  - It clears to 0 on any temp_ok=1 tick and on leaving RUN/HOLD.
  - When the counter reaches ALARM_MS, alarm is set to 1 and the counter saturates.
  - alarm clears only on entry to IDLE or on rst. temp_ok recovery does not clear it.
- Not defined: the counter is absent and alarm is tied to 0.

Test Plan:
All scenarios use STAGE_MS=4, LAST_STAGE=11, ALARM_MS=6.
1. Reset, then start pulse with temp_ok=1 held -> st=1 next edge; num steps 0,1,2... every 4 clocks; num=11 with done=1 after 44 clocks; num then stays 11.
2. RUN with temp_ok=0 for 10 clocks mid-stage (ms_cnt=2) -> num and ms_cnt hold; temp=1 one cycle after the drop; after recovery, num advances 2 clocks later.
3. Stop pulse at num=5, ms_cnt=1 -> HOLD with num=5 for 20 clocks; start pulse -> num=6 after 3 more in-range clocks. Second stop while in HOLD -> IDLE, num=0, st=0.
4. start_key and stop_key asserted in the same cycle during RUN -> HOLD. Same pair asserted in IDLE -> remains IDLE. Stop coinciding with the terminal tick -> num unchanged.
5. rst asserted asynchronously mid-RUN at num=7, between clock edges -> num=0, st=0, temp=0, done=0 immediately, without waiting for clk.
6. HATCH_ALARM_EN defined: temp_ok=0 for 6 ticks in RUN -> alarm=1; temp_ok back to 1 -> alarm stays 1; stop, stop -> IDLE and alarm=0. Macro undefined: alarm is constant 0 in the same stimulus.

Source files
------------

// File: rtl/hatch_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// hatch_seq_ctrl_if
//   Key/sensor inputs and display-driver outputs of the hatch sequencer,
//   bundled into one interface. clk and rst are not part of it.
//
// Handshake: there is no valid/ready pairing on this bus. start_key and
//   stop_key are single-cycle pulses. Each one is consumed on the clock edge
//   where it is high. temp_ok is a level that is sampled on every edge. All
//   outputs are registered, so they change only on a clock edge or on rst.
//
// Signals
//   start_key  : start/resume/re-arm pulse          (master -> slave)
//   stop_key   : pause/abort pulse                  (master -> slave)
//   temp_ok    : 1 = incubator temperature in range (master -> slave)
//   num[3:0]   : current stage number               (slave -> master)
//   st         : display enable                     (slave -> master)
//   temp       : temperature-fault overlay request  (slave -> master)
//   done       : sequence finished                  (slave -> master)
//   alarm      : sustained temperature fault        (slave -> master)
//   state_dbg  : raw sequencer state, for debug     (slave -> master)
// -----------------------------------------------------------------------------
interface hatch_seq_ctrl_if;
    logic       start_key;
    logic       stop_key;
    logic       temp_ok;
    logic [3:0] num;
    logic       st;
    logic       temp;
    logic       done;
    logic       alarm;
    logic [1:0] state_dbg;

    modport master (
        output start_key,
        output stop_key,
        output temp_ok,
        input  num,
        input  st,
        input  temp,
        input  done,
        input  alarm,
        input  state_dbg
    );

    modport slave (
        input  start_key,
        input  stop_key,
        input  temp_ok,
        output num,
        output st,
        output temp,
        output done,
        output alarm,
        output state_dbg
    );
endinterface

// File: rtl/hatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hatch_seq_ctrl
//   Incubation sequencer for the egg-hatch dot-matrix display. It counts
//   in-range clock ticks into stages. Each stage is STAGE_MS ticks long.
//   The stage number runs 0..LAST_STAGE and the sequence finishes at
//   LAST_STAGE. The start and stop keys pause, resume, abort and re-arm
//   the sequence.
//
// Ports
//   clk  : 1 kHz system clock
//   rst  : asynchronous, active-high reset
//   bus  : hatch_seq_ctrl_if.slave
//            start_key, stop_key, temp_ok in
//            num, st, temp, done, alarm, state_dbg out
//
// Optional feature
//   HATCH_ALARM_EN : when this macro is defined, the block counts
//   consecutive out-of-range ticks while running or held. It raises alarm
//   when the count reaches ALARM_MS. Once raised, alarm stays set until the
//   sequencer re-enters IDLE or rst is applied. When the macro is not
//   defined, alarm is tied to 0.
// -----------------------------------------------------------------------------
module hatch_seq_ctrl #(
    parameter int STAGE_MS   = 1000,
    parameter int LAST_STAGE = 11,
    parameter int ALARM_MS   = 5000
) (
    input  logic             clk,
    input  logic             rst,
    hatch_seq_ctrl_if.slave  bus
);

    // Reject parameter values the counters cannot represent.
    if (STAGE_MS < 2 || LAST_STAGE < 1 || LAST_STAGE > 15 || ALARM_MS < 1) begin : g_param_check
        $error("hatch_seq_ctrl: parameter out of range");
    end

    localparam int             MS_W     = $clog2(STAGE_MS);
    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(STAGE_MS - 1);
    localparam logic [3:0]      NUM_LAST = 4'(LAST_STAGE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [3:0]      num_q, num_d;
    logic            st_q, st_d;
    logic            temp_q, temp_d;
    logic            done_q, done_d;
    logic            alarm_w;

    // -------------------------------------------------------------------------
    // Next-state logic. A stop key always takes priority over a start key.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        num_d    = num_q;

        case (state_q)
            S_IDLE: begin
                ms_cnt_d = '0;
                num_d    = '0;
                // Start and stop together in IDLE: stop wins, so nothing happens.
                if (bus.start_key && !bus.stop_key) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (bus.stop_key) begin
                    // Stop takes priority even over a terminal tick.
                    // The stage progress freezes at its pre-edge value.
                    state_d = S_HOLD;
                end else if (bus.temp_ok) begin
                    if (ms_cnt_q == MS_LAST) begin
                        ms_cnt_d = '0;
                        num_d    = num_q + 4'd1;
                        if (num_q == NUM_LAST - 4'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        ms_cnt_d = ms_cnt_q + MS_W'(1);
                    end
                end
            end

            S_HOLD: begin
                if (bus.stop_key) begin
                    // A second stop aborts the sequence.
                    state_d  = S_IDLE;
                    ms_cnt_d = '0;
                    num_d    = '0;
                end else if (bus.start_key) begin
                    // Resume from the frozen count.
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                num_d    = NUM_LAST;
                ms_cnt_d = '0;
                if (bus.start_key || bus.stop_key) begin
                    state_d  = S_IDLE;
                    num_d    = '0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ms_cnt_d = '0;
                num_d    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. The outputs are decoded from the next state so that the
    // registered values line up with the registered state. The fault overlay
    // shows only while a run is active or held.
    // -------------------------------------------------------------------------
    always_comb begin
        st_d   = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        temp_d = ((state_d == S_RUN) || (state_d == S_HOLD)) && !bus.temp_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ms_cnt_q <= '0;
            num_q    <= '0;
            st_q     <= 1'b0;
            temp_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            num_q    <= num_d;
            st_q     <= st_d;
            temp_q   <= temp_d;
            done_q   <= done_d;
        end
    end

`ifdef HATCH_ALARM_EN
    // -------------------------------------------------------------------------
    // Sustained-fault alarm. The bad-tick counter only runs while the
    // sequencer stays inside RUN/HOLD. Any in-range tick clears the counter,
    // and so does leaving RUN/HOLD. Once the counter reaches ALARM_MS it
    // saturates.
    // -------------------------------------------------------------------------
    localparam int              BAD_W   = $clog2(ALARM_MS + 1);
    localparam logic [BAD_W-1:0] BAD_MAX = BAD_W'(ALARM_MS);
    localparam logic [BAD_W-1:0] BAD_PRE = BAD_W'(ALARM_MS - 1);

    logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;
    logic             alarm_q, alarm_d;
    logic             act_q, act_d;

    always_comb begin
        bad_cnt_d = bad_cnt_q;
        alarm_d   = alarm_q;
        act_q     = (state_q == S_RUN) || (state_q == S_HOLD);
        act_d     = (state_d == S_RUN) || (state_d == S_HOLD);

        if (act_q && act_d && !bus.temp_ok) begin
            if (bad_cnt_q >= BAD_PRE) begin
                bad_cnt_d = BAD_MAX;
                alarm_d   = 1'b1;
            end else begin
                bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
        end else begin
            bad_cnt_d = '0;
        end

        // Temperature recovery alone does not clear the alarm; returning to IDLE does.
        if (state_d == S_IDLE) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_cnt_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            bad_cnt_q <= bad_cnt_d;
            alarm_q   <= alarm_d;
        end
    end

    assign alarm_w = alarm_q;
`else
    assign alarm_w = 1'b0;
`endif

    assign bus.num       = num_q;
    assign bus.st        = st_q;
    assign bus.temp      = temp_q;
    assign bus.done      = done_q;
    assign bus.alarm     = alarm_w;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_hatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hatch_seq_ctrl
//   Directed bench for hatch_seq_ctrl with STAGE_MS=4, LAST_STAGE=11 and
//   ALARM_MS=6. The reference model tracks the total number of in-range
//   ticks in the current sequence, and the expected stage is that total
//   divided by STAGE_MS. Inputs change on the falling edge. Outputs are
//   compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_hatch_seq_ctrl;

    localparam int STAGE_MS   = 4;
    localparam int LAST_STAGE = 11;
    localparam int ALARM_MS   = 6;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hatch_seq_ctrl_if bus ();

    hatch_seq_ctrl #(
        .STAGE_MS   (STAGE_MS),
        .LAST_STAGE (LAST_STAGE),
        .ALARM_MS   (ALARM_MS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode  = M_IDLE;
    int m_prog  = 0;      // in-range ticks accumulated in this sequence
    int m_temp  = 0;
    int m_bad   = 0;
    int m_alarm = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_prog = 0; m_temp = 0; m_bad = 0; m_alarm = 0;
        end else begin
            int  old_mode;
            bit  s, p, t;
            old_mode = m_mode;
            s = bus.start_key; p = bus.stop_key; t = bus.temp_ok;
            case (m_mode)
                M_IDLE: if (s && !p) begin m_mode = M_RUN; m_prog = 0; end
                M_RUN: begin
                    if (p) m_mode = M_HOLD;
                    else if (t) begin
                        m_prog++;
                        if (m_prog == LAST_STAGE * STAGE_MS) m_mode = M_DONE;
                    end
                end
                M_HOLD: begin
                    if (p) begin m_mode = M_IDLE; m_prog = 0; end
                    else if (s) m_mode = M_RUN;
                end
                default: if (s || p) begin m_mode = M_IDLE; m_prog = 0; end
            endcase
            m_temp = ((m_mode == M_RUN || m_mode == M_HOLD) && !t) ? 1 : 0;
`ifdef HATCH_ALARM_EN
            if ((old_mode == M_RUN || old_mode == M_HOLD) &&
                (m_mode == M_RUN || m_mode == M_HOLD) && !t) begin
                m_bad = (m_bad + 1 > ALARM_MS) ? ALARM_MS : m_bad + 1;
                if (m_bad == ALARM_MS) m_alarm = 1;
            end else m_bad = 0;
            if (m_mode == M_IDLE) m_alarm = 0;
`else
            if (old_mode < 0) m_bad = 0;
`endif
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("num",   int'(bus.num),   m_prog / STAGE_MS);
            chk("st",    int'(bus.st),    (m_mode != M_IDLE) ? 1 : 0);
            chk("done",  int'(bus.done),  (m_mode == M_DONE) ? 1 : 0);
            chk("temp",  int'(bus.temp),  m_temp);
            chk("alarm", int'(bus.alarm), m_alarm);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit s, input bit p, input bit t);
        bus.start_key = s;
        bus.stop_key  = p;
        bus.temp_ok   = t;
        @(negedge clk);
    endtask

    task automatic run_ok(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    int exp_alarm;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.start_key = 0; bus.stop_key = 0; bus.temp_ok = 1;
        repeat (2) @(negedge clk);
        chk("rst_num",  int'(bus.num),  0);
        chk("rst_st",   int'(bus.st),   0);
        chk("rst_temp", int'(bus.temp), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_alarm", int'(bus.alarm), 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // 1: full sequence with the temperature always in range
        step(1, 0, 1);
        chk("t1_st_after_start", int'(bus.st), 1);
        chk("t1_num_start", int'(bus.num), 0);
        run_ok(3);
        chk("t1_num_3ticks", int'(bus.num), 0);
        run_ok(1);
        chk("t1_num_4ticks", int'(bus.num), 1);
        run_ok(39);
        chk("t1_num_43ticks", int'(bus.num), 10);
        chk("t1_done_early", int'(bus.done), 0);
        run_ok(1);
        chk("t1_num_final", int'(bus.num), 11);
        chk("t1_done", int'(bus.done), 1);
        run_ok(3);
        chk("t1_num_stays", int'(bus.num), 11);
        step(0, 1, 1);
        chk("t1_idle_st", int'(bus.st), 0);
        chk("t1_idle_num", int'(bus.num), 0);

        // 2: temperature drop in the middle of a stage
        step(1, 0, 1);
        run_ok(2);
        step(0, 0, 0);
        chk("t2_temp_flag", int'(bus.temp), 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        chk("t2_num_hold", int'(bus.num), 0);
        step(0, 0, 1);
        chk("t2_temp_clear", int'(bus.temp), 0);
        chk("t2_num_1_after", int'(bus.num), 0);
        step(0, 0, 1);
        chk("t2_num_2_after", int'(bus.num), 1);
        step(0, 1, 1);
        step(0, 1, 1);

        // 3: pause at num=5, ms=1; resume; abort from HOLD
        step(1, 0, 1);
        run_ok(21);
        chk("t3_num5", int'(bus.num), 5);
        step(0, 1, 1);
        run_ok(20);
        chk("t3_hold_num", int'(bus.num), 5);
        chk("t3_hold_st", int'(bus.st), 1);
        step(1, 0, 1);
        run_ok(2);
        chk("t3_resume_2", int'(bus.num), 5);
        run_ok(1);
        chk("t3_resume_3", int'(bus.num), 6);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("t3_abort_num", int'(bus.num), 0);
        chk("t3_abort_st", int'(bus.st), 0);

        // 4: start and stop together; stop on the terminal tick
        step(1, 0, 1);
        run_ok(5);
        step(1, 1, 1);
        run_ok(4);
        chk("t4_both_run_hold", int'(bus.num), 1);
        step(0, 1, 1);
        step(1, 1, 1);
        chk("t4_both_idle_st", int'(bus.st), 0);
        step(0, 0, 1);
        chk("t4_idle_stays", int'(bus.st), 0);
        step(1, 0, 1);
        run_ok(3);
        step(0, 1, 1);
        chk("t4_stop_terminal", int'(bus.num), 0);
        step(1, 0, 1);
        step(0, 0, 1);
        chk("t4_resume_term", int'(bus.num), 1);
        step(0, 1, 1);
        step(0, 1, 1);

        // 5: asynchronous reset applied mid-run
        step(1, 0, 1);
        run_ok(28);
        chk("t5_num7", int'(bus.num), 7);
        bus.temp_ok = 0;
        #3 rst = 1'b1;
        #1;
        chk("t5_arst_num",  int'(bus.num),  0);
        chk("t5_arst_st",   int'(bus.st),   0);
        chk("t5_arst_temp", int'(bus.temp), 0);
        chk("t5_arst_done", int'(bus.done), 0);
        @(negedge clk);
        bus.temp_ok = 1;
        #1 rst = 1'b0;
        @(negedge clk);

        // 6: sustained fault alarm
`ifdef HATCH_ALARM_EN
        exp_alarm = 1;
`else
        exp_alarm = 0;
`endif
        step(1, 0, 1);
        run_ok(2);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("t6_alarm_5", int'(bus.alarm), 0);
        step(0, 0, 0);
        chk("t6_alarm_6", int'(bus.alarm), exp_alarm);
        step(0, 0, 1);
        chk("t6_alarm_recover", int'(bus.alarm), exp_alarm);
        step(0, 1, 1);
        chk("t6_alarm_hold", int'(bus.alarm), exp_alarm);
        step(0, 1, 1);
        chk("t6_alarm_idle", int'(bus.alarm), 0);
        run_ok(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
